// File: rtl/fir_axil_pkg.sv
// Shared definitions for the FIR AXI4-Lite configuration initiator:
// controller state encoding, FIR register map and ap_ctrl bit positions.
package fir_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD_A = 3'd2,
        ST_RD_D = 3'd3,
        ST_RESP = 3'd4
    } axil_state_e;

    // FIR configuration register offsets (byte addresses)
    localparam logic [11:0] AP_CTRL_OFF  = 12'h000;
    localparam logic [11:0] DATA_LEN_OFF = 12'h010;
    localparam logic [11:0] NUM_TAP_OFF  = 12'h014;
    localparam logic [11:0] TAP_BASE_OFF = 12'h080;
    localparam logic [11:0] TAP_END_OFF  = 12'h0FF;

    // ap_ctrl bit positions
    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    // True when the address falls inside the tap coefficient RAM window
    function automatic logic is_tap_addr(input logic [11:0] addr);
        return (addr >= TAP_BASE_OFF) && (addr <= TAP_END_OFF);
    endfunction

endpackage

// File: rtl/fir_axil_master_if.sv
// Command/response port and AXI4-Lite (AW, W, AR, R) signals of the FIR
// configuration initiator. The master modport is the initiator's view;
// the slave modport is the view of whoever sits on the other side
// (sequencer on cmd/rsp, FIR register target on the AXI channels).
interface fir_axil_master_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [pADDR_WIDTH-1:0] cmd_addr;
    logic [pDATA_WIDTH-1:0] cmd_wdata;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [pDATA_WIDTH-1:0] rsp_rdata;
    logic                   rsp_err;

    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        input  awready, wready, arready, rvalid, rdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        output awready, wready, arready, rvalid, rdata
    );

endinterface

// File: rtl/axil_timeout_cnt.sv
// Clearable saturating cycle counter. o_expire is high while counting is
// enabled and the count has reached pTIMEOUT-1.
module axil_timeout_cnt #(
    parameter int pTIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int CW = (pTIMEOUT > 2) ? $clog2(pTIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(pTIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Count enabled cycles, restart on clear, stick at the last value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expire = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/fir_axil_master.sv
// AXI4-Lite initiator for the FIR configuration port. Accepts one command
// at a time, runs it as a single AXI4-Lite write (AW+W, no B channel) or
// read (AR then R), and returns exactly one response. A watchdog aborts any
// wait state that lasts pTIMEOUT cycles and reports rsp_err.
module fir_axil_master
    import fir_axil_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 64
) (
    input  logic                axis_clk,
    input  logic                axis_rst,
    fir_axil_master_if.master   bus
);

    axil_state_e            r_state,     w_state_nxt;
    logic                   r_cmd_ready, w_cmd_ready_nxt;
    logic                   r_rsp_valid, w_rsp_valid_nxt;
    logic [pDATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic                   r_rsp_err,   w_rsp_err_nxt;
    logic                   r_awvalid,   w_awvalid_nxt;
    logic                   r_wvalid,    w_wvalid_nxt;
    logic                   r_arvalid,   w_arvalid_nxt;
    logic                   r_rready,    w_rready_nxt;
    logic [pADDR_WIDTH-1:0] r_awaddr,    w_awaddr_nxt;
    logic [pDATA_WIDTH-1:0] r_wdata,     w_wdata_nxt;
    logic [pADDR_WIDTH-1:0] r_araddr,    w_araddr_nxt;
    logic                   r_aw_done,   w_aw_done_nxt;
    logic                   r_w_done,    w_w_done_nxt;

    logic w_cnt_en;
    logic w_cnt_clear;
    logic w_expire;

    // The watchdog runs only in bus wait states and restarts on every
    // state change, so each wait state gets its own full budget.
    assign w_cnt_en    = (r_state == ST_WR) || (r_state == ST_RD_A) || (r_state == ST_RD_D);
    assign w_cnt_clear = (w_state_nxt != r_state) || !w_cnt_en;

    axil_timeout_cnt #(
        .pTIMEOUT (pTIMEOUT)
    ) u_timeout (
        .clk      (axis_clk),
        .rst      (axis_rst),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_en),
        .o_expire (w_expire)
    );

    // Next-state and next-output decode; a completing handshake always
    // takes priority over watchdog expiry in the same cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_awaddr_nxt    = r_awaddr;
        w_wdata_nxt     = r_wdata;
        w_araddr_nxt    = r_araddr;
        w_aw_done_nxt   = r_aw_done;
        w_w_done_nxt    = r_w_done;

        case (r_state)
            ST_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    if (bus.cmd_write) begin
                        w_awaddr_nxt  = bus.cmd_addr;
                        w_wdata_nxt   = bus.cmd_wdata;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_aw_done_nxt = 1'b0;
                        w_w_done_nxt  = 1'b0;
                        w_state_nxt   = ST_WR;
                    end else begin
                        w_araddr_nxt  = bus.cmd_addr;
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = ST_RD_A;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_WR: begin
                w_aw_done_nxt = r_aw_done | (r_awvalid & bus.awready);
                w_w_done_nxt  = r_w_done  | (r_wvalid  & bus.wready);
                if (w_aw_done_nxt) begin
                    w_awvalid_nxt = 1'b0;
                end else begin
                    w_awvalid_nxt = r_awvalid;
                end
                if (w_w_done_nxt) begin
                    w_wvalid_nxt = 1'b0;
                end else begin
                    w_wvalid_nxt = r_wvalid;
                end
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_nxt     = ST_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = '0;
                end else if (w_expire) begin
                    w_awvalid_nxt   = 1'b0;
                    w_wvalid_nxt    = 1'b0;
                    w_state_nxt     = ST_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end else begin
                    w_state_nxt = ST_WR;
                end
            end

            ST_RD_A: begin
                if (r_arvalid && bus.arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = ST_RD_D;
                end else if (w_expire) begin
                    w_arvalid_nxt   = 1'b0;
                    w_state_nxt     = ST_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end else begin
                    w_state_nxt = ST_RD_A;
                end
            end

            ST_RD_D: begin
                if (bus.rvalid && r_rready) begin
                    w_rready_nxt    = 1'b0;
                    w_state_nxt     = ST_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = bus.rdata;
                end else if (w_expire) begin
                    w_rready_nxt    = 1'b0;
                    w_state_nxt     = ST_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end else begin
                    w_state_nxt = ST_RD_D;
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_cmd_ready_nxt = 1'b0;
                w_rsp_valid_nxt = 1'b0;
                w_awvalid_nxt   = 1'b0;
                w_wvalid_nxt    = 1'b0;
                w_arvalid_nxt   = 1'b0;
                w_rready_nxt    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_araddr    <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_araddr    <= w_araddr_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.awvalid   = r_awvalid;
    assign bus.awaddr    = r_awaddr;
    assign bus.wvalid    = r_wvalid;
    assign bus.wdata     = r_wdata;
    assign bus.arvalid   = r_arvalid;
    assign bus.araddr    = r_araddr;
    assign bus.rready    = r_rready;

endmodule
